// File: rtl/imem_arbiter.sv
// Two-port round-robin arbiter in front of a single instruction-memory port.
// One access in flight at a time; a watchdog retires accesses the memory never answers.
module imem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_valid,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  output logic                  p0_ready,
  output logic [31:0]           p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_valid,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  output logic                  p1_ready,
  output logic [31:0]           p1_rdata,
  output logic                  p1_err,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  // The counter only has to reach TIMEOUT_CYCLES-1 before the abort fires.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic                  grant;
  logic                  last_grant;
  logic [CW-1:0]         count;
  logic [1:0]            ready_reg;
  logic [1:0]            err_reg;
  logic [31:0]           rdata_reg [2];
  logic [1:0]            valid;
  logic [1:0]            eligible;
  logic [ADDR_WIDTH-1:0] addr [2];
  logic                  pick;
  logic                  timeout_hit;

  assign valid   = {p1_valid, p0_valid};
  assign addr[0] = p0_addr;
  assign addr[1] = p1_addr;

  // A port retiring this cycle must not be re-granted on the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign eligible[gi] = valid[gi] & ~ready_reg[gi];
    end
  endgenerate

  assign pick        = (eligible == 2'b11) ? ~last_grant : eligible[1];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      ready_reg    <= '0;
      err_reg      <= '0;
      rdata_reg[0] <= '0;
      rdata_reg[1] <= '0;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      count        <= '0;
    end else begin
      ready_reg <= '0;
      err_reg   <= '0;
      if (state == IDLE) begin
        if (|eligible) begin
          mem_valid  <= 1'b1;
          mem_addr   <= addr[pick];
          grant      <= pick;
          last_grant <= pick;
          count      <= '0;
          state      <= BUSY;
        end
      end else begin
        // A response on the final watchdog cycle still counts as a normal completion.
        if (mem_ready) begin
          ready_reg[grant] <= 1'b1;
          rdata_reg[grant] <= mem_rdata;
          mem_valid        <= 1'b0;
          state            <= IDLE;
        end else if (timeout_hit) begin
          ready_reg[grant] <= 1'b1;
          err_reg[grant]   <= 1'b1;
          rdata_reg[grant] <= '0;
          mem_valid        <= 1'b0;
          state            <= IDLE;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  assign p0_ready = ready_reg[0];
  assign p0_err   = err_reg[0];
  assign p0_rdata = rdata_reg[0];
  assign p1_ready = ready_reg[1];
  assign p1_err   = err_reg[1];
  assign p1_rdata = rdata_reg[1];

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus a randomized phase, checked each
// cycle against a transaction-level model of grant order, completion time and data.
module tb_imem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_valid [2];
  logic [31:0] p_addr  [2];
  logic        p0_ready, p1_ready, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit          m_busy;
  int          m_port;
  int          m_done;
  bit          m_err;
  logic [31:0] m_data;
  logic [31:0] m_addr;
  int          m_last;
  int          edge_cnt;
  bit          exp_ready [2];
  bit          exp_err   [2];
  logic [31:0] exp_rdata [2];
  bit          exp_mv;
  logic [31:0] exp_ma;
  int          lat;
  int          mcnt;
  int          mv_rises;
  bit          prev_mv;

  imem_arbiter #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p_valid[0]), .p0_addr(p_addr[0]), .p0_ready(p0_ready), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p_valid[1]), .p1_addr(p_addr[1]), .p1_ready(p1_ready), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int x);
    return (x == 1) ? p1_ready : p0_ready;
  endfunction

  // One clock: predict from the transaction rules, compare, then play the memory.
  task automatic tick();
    bit e0, e1;
    int w;
    e0 = p_valid[0] && !exp_ready[0];
    e1 = p_valid[1] && !exp_ready[1];
    @(posedge clk);
    #1;
    edge_cnt++;
    exp_ready = '{0, 0};
    exp_err   = '{0, 0};
    if (reset) begin
      m_busy = 0; m_last = 1; exp_mv = 0; exp_ma = '0;
      exp_rdata = '{32'h0, 32'h0};
    end else if (m_busy) begin
      if (edge_cnt == m_done) begin
        exp_ready[m_port] = 1;
        exp_err[m_port]   = m_err;
        exp_rdata[m_port] = m_data;
        m_busy = 0;
        exp_mv = 0;
        $display("txn port=%0d addr=0x%h rdata=0x%h err=%0d", m_port, m_addr, m_data, m_err);
      end
    end else if (e0 || e1) begin
      w = (e0 && e1) ? (1 - m_last) : (e1 ? 1 : 0);
      m_last = w; m_port = w; m_busy = 1;
      m_addr = p_addr[w];
      exp_mv = 1; exp_ma = m_addr;
      if (lat >= 0 && lat + 1 <= TO) begin
        m_done = edge_cnt + lat + 1; m_err = 0; m_data = memword(m_addr);
      end else begin
        m_done = edge_cnt + TO; m_err = 1; m_data = '0;
      end
    end
    chk("p0_ready",  p0_ready,  exp_ready[0]);
    chk("p0_err",    p0_err,    exp_err[0]);
    chk("p0_rdata",  p0_rdata,  exp_rdata[0]);
    chk("p1_ready",  p1_ready,  exp_ready[1]);
    chk("p1_err",    p1_err,    exp_err[1]);
    chk("p1_rdata",  p1_rdata,  exp_rdata[1]);
    chk("mem_valid", mem_valid, exp_mv);
    chk("mem_addr",  mem_addr,  exp_ma);
    if (mem_valid === 1'b1 && !prev_mv) mv_rises++;
    prev_mv = (mem_valid === 1'b1);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (mem_valid === 1'b1) begin
      mcnt++;
      if (lat >= 0 && mcnt == lat + 1) begin
        mem_ready = 1'b1;
        mem_rdata = memword(mem_addr);
      end
    end else begin
      mcnt = 0;
    end
  endtask

  task automatic wait_port(input int x, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rdy(x) && n < max);
    chk($sformatf("wait_p%0d", x), rdy(x), 1'b1);
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && m_busy; c++) tick();
    tick();
  endtask

  initial begin
    int n;
    int rises0;
    int order [$];

    reset = 1'b1;
    p_valid = '{0, 0};
    p_addr  = '{32'h0, 32'h0};
    mem_ready = 1'b0;
    mem_rdata = '0;
    lat = 1; mcnt = 0; edge_cnt = 0; m_busy = 0; m_last = 1;
    exp_ready = '{0, 0}; exp_err = '{0, 0}; exp_rdata = '{32'h0, 32'h0};
    exp_mv = 0; exp_ma = '0; mv_rises = 0; prev_mv = 0;
    tick();
    tick();
    reset = 1'b0;

    // single read through a one-cycle memory
    p_valid[0] = 1; p_addr[0] = 32'h100;
    tick();
    chk("t1_mem_valid", mem_valid, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    n = 1;
    tick(); n++;
    if (!p0_ready) begin tick(); n++; end
    chk("t1_latency", n, 3);
    chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
    chk("t1_err", p0_err, 1'b0);
    chk("t1_p1_ready", p1_ready, 1'b0);
    p_valid[0] = 0;
    drain();

    // both ports requesting continuously from reset
    reset = 1'b1;
    p_valid = '{1, 1};
    p_addr  = '{32'h0, 32'h4};
    tick();
    reset = 1'b0;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      tick();
      for (int x = 0; x < 2; x++) begin
        if (rdy(x)) begin
          order.push_back(x);
          if (order.size() == 1) chk("t2_first_data", p0_rdata, memword(32'h0));
          p_addr[x] = p_addr[x] + 32'h10;
        end
      end
    end
    p_valid = '{0, 0};
    chk("t2_count", order.size(), 4);
    foreach (order[i]) chk($sformatf("t2_order%0d", i), order[i], i % 2);
    drain();

    // back-to-back requests from port 1
    rises0 = mv_rises;
    p_valid[1] = 1; p_addr[1] = 32'h8;
    wait_port(1, 20, n);
    chk("t3_data0", p1_rdata, memword(32'h8));
    p_valid[1] = 0;
    tick();
    p_valid[1] = 1; p_addr[1] = 32'hC;
    wait_port(1, 20, n);
    chk("t3_data1", p1_rdata, memword(32'hC));
    p_valid[1] = 0;
    drain();
    chk("t3_accesses", mv_rises - rises0, 2);

    // memory never answers: watchdog, then a late stray response
    lat = -1;
    p_valid[0] = 1; p_addr[0] = 32'h20;
    wait_port(0, 20, n);
    chk("t4_latency", n, 5);
    chk("t4_err", p0_err, 1'b1);
    chk("t4_rdata", p0_rdata, 32'h0);
    chk("t4_mem_valid", mem_valid, 1'b0);
    p_valid[0] = 0;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    chk("t4_late_ignored", p0_ready, 1'b0);
    lat = 1;
    p_valid[1] = 1; p_addr[1] = 32'h30;
    wait_port(1, 20, n);
    chk("t4_p1_data", p1_rdata, memword(32'h30));
    chk("t4_p1_err", p1_err, 1'b0);
    p_valid[1] = 0;
    drain();

    // response on the last watchdog cycle wins
    lat = 3;
    p_valid[0] = 1; p_addr[0] = 32'h44;
    wait_port(0, 20, n);
    chk("t5_latency", n, 5);
    chk("t5_err", p0_err, 1'b0);
    chk("t5_data", p0_rdata, memword(32'h44));
    p_valid[0] = 0;
    drain();

    // reset while port 1 is outstanding
    lat = 5;
    p_valid[1] = 1; p_addr[1] = 32'h50;
    tick(); tick(); tick();
    reset = 1'b1; p_valid[1] = 0;
    tick();
    chk("t6_no_ready", p1_ready, 1'b0);
    chk("t6_mem_valid", mem_valid, 1'b0);
    chk("t6_rdata", p1_rdata, 32'h0);
    reset = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    chk("t6_late_ignored", p1_ready, 1'b0);
    lat = 1;
    p_valid[1] = 1; p_addr[1] = 32'h54;
    wait_port(1, 20, n);
    chk("t6_p1_data", p1_rdata, memword(32'h54));
    p_valid[1] = 0;
    drain();

    // randomized traffic with random memory latency, some past the watchdog
    for (int c = 0; c < 600; c++) begin
      tick();
      if (!m_busy) lat = $urandom_range(0, 5);
      for (int x = 0; x < 2; x++) begin
        if (exp_ready[x]) begin
          if ($urandom_range(0, 1) == 1) p_addr[x] = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
          else p_valid[x] = 0;
        end else if (!p_valid[x] && $urandom_range(0, 2) == 0) begin
          p_valid[x] = 1;
          p_addr[x]  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        end
      end
    end
    p_valid = '{0, 0};
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
